traffic_light_safety_monitor: RTL

//  Downstream stage of Traffic_Light_Controller: takes its four light vectors, checks them
//  for illegal codes, conflicting movements and short yellow, and drives the physical lamps.
//  On a violation it latches a fault, forces flashing red on all approaches and holds it

---
 rtl/traffic_light_safety_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor: vets controller light vectors, drives lamps, latches faults into flashing red.
// Optional stuck-input watchdog enabled by defining WATCHDOG_EN.
module traffic_light_safety_monitor #(
  parameter int FLASH_HALF   = 5,
  parameter int MIN_YELLOW   = 2,
  parameter int SYNC_CYCLES  = 4,
  parameter int STUCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_M2_in,
  input  logic [2:0] light_MT_in,
  input  logic [2:0] light_S_in,
  input  logic       fault_clr,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int SW = $clog2(SYNC_CYCLES + 1);
  typedef enum logic [1:0] {S_WAIT, S_PASS, S_FAULT} state_t;
  state_t r_state, w_state_nx;
  logic [3:0][2:0] w_in, r_prev, r_lamp, w_lamp_nx;
  logic [3:0][YW-1:0] r_ycnt;
  logic [3:0] w_go;
  logic [2:0] r_code, w_code, w_code_nx;
  logic [SW-1:0] r_sync, w_sync_nx;
  logic [FW-1:0] r_flash, w_flash_nx;
  logic r_on, w_on_nx, w_illegal, w_short, w_conflict, w_stuck, w_flip;
  assign w_in = {light_S_in, light_MT_in, light_M2_in, light_M1_in};
  assign w_go = {|light_S_in[1:0], |light_MT_in[1:0], |light_M2_in[1:0], |light_M1_in[1:0]};
  assign w_conflict = (w_go[3] & (w_go[0] | w_go[1] | w_go[2])) | (w_go[2] & w_go[1]);
  always_comb begin
    w_illegal = 1'b0;
    w_short = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_illegal = w_illegal | !$onehot(w_in[k]);
      w_short = w_short | (w_in[k] == RED && (r_prev[k] == GRN ||
                (r_prev[k] == YEL && r_ycnt[k] < YW'(MIN_YELLOW))));
    end
  end
`ifdef WATCHDOG_EN
  localparam int KW = $clog2(STUCK_CYCLES + 1);
  logic [KW-1:0] r_stuck;
  logic w_same;
  assign w_same = w_in == r_prev;
  assign w_stuck = r_state == S_PASS && w_same && r_stuck == KW'(STUCK_CYCLES - 1);
  always_ff @(posedge clk)
    r_stuck <= (rst || r_state != S_PASS || !w_same) ? '0 : r_stuck + 1'b1;
`else
  assign w_stuck = STUCK_CYCLES < 0;
`endif
  assign w_code = w_illegal ? 3'd1 : w_conflict ? 3'd2 : w_short ? 3'd3 : w_stuck ? 3'd4 : 3'd0;
  assign w_flip = r_flash == FW'(FLASH_HALF - 1);
  always_comb begin
    w_state_nx = r_state;
    w_lamp_nx = {4{RED}};
    w_code_nx = r_code;
    w_sync_nx = '0;
    w_flash_nx = '0;
    w_on_nx = 1'b1;
    case (r_state)
      S_PASS: begin
        if (w_code != 3'd0) begin
          w_state_nx = S_FAULT;
          w_code_nx = w_code;
        end else w_lamp_nx = w_in;
      end
      S_WAIT: begin
        if (w_code != 3'd0) begin
          w_state_nx = S_FAULT;
          w_code_nx = w_code;
        end else if (r_sync == SW'(SYNC_CYCLES - 1)) begin
          w_state_nx = S_PASS;
          w_code_nx = 3'd0;
        end else w_sync_nx = r_sync + 1'b1;
      end
      S_FAULT: begin
        if (fault_clr) w_state_nx = S_WAIT;
        else begin
          w_flash_nx = w_flip ? '0 : r_flash + 1'b1;
          w_on_nx = w_flip ? !r_on : r_on;
          w_lamp_nx = w_on_nx ? {4{RED}} : '0;
        end
      end
      default: w_state_nx = S_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_lamp <= {4{RED}};
      r_code <= '0;
      r_prev <= '0;
      r_ycnt <= '0;
      r_sync <= '0;
      r_flash <= '0;
      r_on <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_lamp <= w_lamp_nx;
      r_code <= w_code_nx;
      r_prev <= w_in;
      r_sync <= w_sync_nx;
      r_flash <= w_flash_nx;
      r_on <= w_on_nx;
      for (int k = 0; k < 4; k++)
        r_ycnt[k] <= w_in[k] != YEL ? '0 : r_ycnt[k] == YW'(MIN_YELLOW) ? r_ycnt[k] : r_ycnt[k] + 1'b1;
    end
  end
  assign {lamp_S, lamp_MT, lamp_M2, lamp_M1} = r_lamp;
  assign fault = r_state == S_FAULT;
  assign fault_code = r_code;
endmodule
